cpu_instruction_sequencer: RTL and testbench
============================================

// Module: cpu_instruction_sequencer
// PURPOSE
//  Initiator for the 4-bit CPU's external instruction/execute interface.
//  Holds a small program, presents each 8-bit instruction, pulses execute, and waits for the
//  CPU's Done. It captures the CPU's LED result after every instruction, then advances.
//  Replaces the manual switch/button stepping used on the board; sits between the board
//  control logic and simple_4bit_processor.
// PARAMETERS
//  DEPTH      16  program slots (power of 2)
//  ADDR_W     4   log2(DEPTH)
//  SETUP_CYC  1   cycles instruction is held stable before execute rises (>=1)
//  EXEC_CYC   1   cycles execute is held high (>=1)
//  TIMEOUT    15  max cycles in WAIT_DONE before error (>=1)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low; clears all state
//  load_en      in   1       write load_data into program slot load_addr (ignored while busy)
//  load_addr    in   ADDR_W  program slot to write
//  load_data    in   8       instruction to store
//  prog_len     in   ADDR_W+1 number of instructions to run, sampled on start (0..DEPTH)
//  start        in   1       begin run from slot 0 (ignored while busy)
//  cpu_done     in   1       CPU Done
//  cpu_leds     in   4       CPU LEDs
//  instruction  out  8       instruction to CPU
//  execute      out  1       execute strobe to CPU
//  busy         out  1       run in progress
//  pc           out  ADDR_W  slot currently issued
//  result_leds  out  4       cpu_leds captured at last Done rising edge
//  result_valid out  1       1-cycle pulse when result_leds updates
//  finished     out  1       1-cycle pulse on normal completion
//  timeout_err  out  1       sticky; set on Done timeout, cleared by next accepted start
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE.
//   - All outputs are 0: instruction=8'h00, execute=0, busy=0, pc=0, result_leds=0,
//     result_valid=0, finished=0, timeout_err=0.
//   - Program RAM contents are not cleared.
//  cpu_done is registered once (done_q); a Done rising edge is cpu_done & ~done_q.
//  FSM:
//   - IDLE: on start and prog_len==0, pulse finished next cycle and stay IDLE.
//     On start and prog_len>0: latch len, pc=0, clear timeout_err, busy=1, go SETUP.
//   - SETUP: instruction=prog[pc], execute=0, for SETUP_CYC cycles; then go PULSE.
//   - PULSE: execute=1 for EXEC_CYC cycles, instruction unchanged; then go WAIT_DONE.
//   - WAIT_DONE: execute=0, instruction held.
//     On a Done rising edge: result_leds<=cpu_leds, result_valid pulses, go NEXT.
//     After TIMEOUT cycles with no edge: timeout_err<=1, busy<=0, execute=0, go IDLE.
//     Edges seen during SETUP/PULSE do not count.
//   - NEXT (1 cycle): if pc==len-1, then finished pulses, busy<=0, pc holds, go IDLE.
//     Otherwise pc<=pc+1, go SETUP.
//  Timing:
//   - Start to first execute rise: 1+SETUP_CYC cycles.
//   - Done edge to next execute rise: 2+SETUP_CYC cycles.
//  Control rules:
//   - prog_len>DEPTH is saturated to DEPTH.
//   - pc never wraps within a run.
//   - start while busy is ignored.
//   - load_en while busy is ignored.
//   - If load_en and start occur in the same cycle while IDLE, the write lands first;
//     the run sees the new data.
//   - reset asserted mid-run aborts immediately to the reset values above.
//   - A simultaneous Done edge and timeout expiry counts as Done (no error).
// STRUCTURE
//  Shared package cpu_pkg:
//   - INSTR_W=8, LED_W=4.
//   - Opcode constants OP_LOAD=2'b00, OP_STORE=2'b01, OP_MOVE=2'b10, OP_ADD=2'b11
//     (instruction[7:6]).
//   - FSM state encoding.
//  One sub-module, seq_prog_ram: DEPTH x 8 with a synchronous write port and an
//  asynchronous read port addressed by pc.
//  Counters: setup/exec cycle counter, timeout counter, pc.
// TESTING (responder model: raises cpu_done 3 cycles after execute falls, holds 2 cycles)
//  1. Load 0x0A,0x15,0xC4 in slots 0-2; prog_len=3; start; model LEDs=4'hF on third Done.
//     -> 3 execute pulses, pc 0..2, result_valid x3, result_leds=F, finished once.
//  2. Check instruction timing. -> instruction matches slot data >=SETUP_CYC cycles before
//     each execute rise and is stable until the Done edge.
//  3. Model never raises Done. -> timeout_err=1 exactly TIMEOUT cycles after entering
//     WAIT_DONE; busy=0, execute=0. A following start clears timeout_err.
//  4. Drop reset mid-PULSE on slot 1. -> execute, busy, pc and result_leds are 0 the same
//     cycle. After release, a new start runs from slot 0.
//  5. Start with prog_len=0. -> finished pulse, no execute.
//     Start with prog_len=17 (DEPTH=16). -> exactly 16 instructions issued.
//  6. During a run, pulse load_en to slot 2 and pulse start.
//     -> both ignored; the original slot-2 instruction is issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes and sequencer state encoding
package cpu_pkg;

    localparam int INSTR_W = 8;
    localparam int LED_W   = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT_DONE,
        ST_NEXT
    } seq_state_t;

    function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 2];
    endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// rtl/seq_prog_ram.sv - program store, synchronous write, asynchronous read
module seq_prog_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Program contents survive reset, so the array has no reset term
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instruction_sequencer.sv
// rtl/cpu_instruction_sequencer.sv - steps a stored program through the CPU execute/done handshake
module cpu_instruction_sequencer
    import cpu_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int EXEC_CYC  = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               cpu_done,
    input  logic [LED_W-1:0]   cpu_leds,
    output logic [INSTR_W-1:0] instruction,
    output logic               execute,
    output logic               busy,
    output logic [ADDR_W-1:0]  pc,
    output logic [LED_W-1:0]   result_leds,
    output logic               result_valid,
    output logic               finished,
    output logic               timeout_err
);

    localparam int CNT_W = 16;

    seq_state_t         state;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [ADDR_W:0]    len;
    logic               done_q;
    logic               done_edge;
    logic               ram_we;
    logic [INSTR_W-1:0] ram_rdata;
    logic [ADDR_W:0]    len_sat;

    // Loads are only honoured while idle so a running program never changes under us
    assign ram_we    = load_en & (state == ST_IDLE);
    assign done_edge = cpu_done & ~done_q;
    assign len_sat   = (prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : prog_len;

    seq_prog_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    // Single register stage on Done so a rising edge can be detected
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= cpu_done;
        end
    end

    // Sequencer FSM with registered CPU-facing and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            tmo_cnt      <= '0;
            len          <= '0;
            pc           <= '0;
            instruction  <= '0;
            execute      <= 1'b0;
            busy         <= 1'b0;
            result_leds  <= '0;
            result_valid <= 1'b0;
            finished     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            finished     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            finished <= 1'b1;
                        end else begin
                            len         <= len_sat;
                            pc          <= '0;
                            timeout_err <= 1'b0;
                            busy        <= 1'b1;
                            phase_cnt   <= '0;
                            state       <= ST_SETUP;
                        end
                    end
                end
                // First SETUP cycle fetches; the remaining SETUP_CYC cycles hold it stable
                ST_SETUP: begin
                    instruction <= ram_rdata;
                    if (phase_cnt == CNT_W'(SETUP_CYC)) begin
                        phase_cnt <= '0;
                        execute   <= 1'b1;
                        state     <= ST_PULSE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (phase_cnt == CNT_W'(EXEC_CYC - 1)) begin
                        phase_cnt <= '0;
                        tmo_cnt   <= '0;
                        execute   <= 1'b0;
                        state     <= ST_WAIT_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                // Done edge has priority over a timeout expiring in the same cycle
                ST_WAIT_DONE: begin
                    if (done_edge) begin
                        result_leds  <= cpu_leds;
                        result_valid <= 1'b1;
                        state        <= ST_NEXT;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        execute     <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if ({1'b0, pc} == len - 1'b1) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        pc        <= pc + 1'b1;
                        phase_cnt <= '0;
                        state     <= ST_SETUP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instruction_sequencer.sv
// tb/tb_cpu_instruction_sequencer.sv - directed self-checking bench for cpu_instruction_sequencer
module tb_cpu_instruction_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic [4:0] prog_len;
    logic       start;
    logic       cpu_done;
    logic [3:0] cpu_leds;
    logic [7:0] instruction;
    logic       execute;
    logic       busy;
    logic [3:0] pc;
    logic [3:0] result_leds;
    logic       result_valid;
    logic       finished;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    cpu_instruction_sequencer #(
        .DEPTH(16), .ADDR_W(4), .SETUP_CYC(1), .EXEC_CYC(1), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start),
        .cpu_done(cpu_done), .cpu_leds(cpu_leds), .instruction(instruction),
        .execute(execute), .busy(busy), .pc(pc), .result_leds(result_leds),
        .result_valid(result_valid), .finished(finished), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // CPU responder: Done rises 3 cycles after execute falls, held 2 cycles
    bit   model_en;
    int   m_wait, m_hold;
    logic m_prev;
    always @(negedge clk) begin
        if (!model_en || !reset) begin
            cpu_done = 1'b0;
            m_wait   = 0;
            m_hold   = 0;
            m_prev   = 1'b0;
        end else begin
            if (m_prev && !execute) begin
                m_wait = 2;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    cpu_done = 1'b1;
                    cpu_leds = instruction[3:0] ^ 4'hB;
                    m_hold   = 2;
                end
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) cpu_done = 1'b0;
            end
            m_prev = execute;
        end
    end

    // Monitor: records issued instructions, results and instruction stability
    int         n_exec, n_rv, n_fin, stab_err, cyc;
    logic [7:0] issued_q[$];
    logic [3:0] pc_q[$];
    logic [3:0] rv_q[$];
    int         exec_cyc_q[$];
    logic       exec_prev = 1'b0;
    logic       holding = 1'b0;
    logic [7:0] held, instr_prev;
    always @(negedge clk) begin
        cyc++;
        if (execute && !exec_prev) begin
            n_exec++;
            issued_q.push_back(instruction);
            pc_q.push_back(pc);
            exec_cyc_q.push_back(cyc);
            if (instruction !== instr_prev) stab_err++;
            holding = 1'b1;
            held    = instruction;
        end else if (holding && instruction !== held) begin
            stab_err++;
        end
        if (result_valid) begin
            n_rv++;
            rv_q.push_back(result_leds);
            holding = 1'b0;
        end
        if (finished) n_fin++;
        if (!busy) holding = 1'b0;
        exec_prev  = execute;
        instr_prev = instruction;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_exec = 0; n_rv = 0; n_fin = 0; stab_err = 0;
        issued_q.delete(); pc_q.delete(); rv_q.delete(); exec_cyc_q.delete();
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] len);
        prog_len = len; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fin(input string tag, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick();
            if (finished === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        bit seen;
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; cpu_leds = '0; model_en = 1'b1;
        clear_mon();
        ticks(3);
        chk("rst_instruction", 32'(instruction), 32'h00);
        chk("rst_execute", 32'(execute), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_result_leds", 32'(result_leds), 32'd0);
        chk("rst_flags", {29'd0, result_valid, finished, timeout_err}, 32'd0);
        reset = 1'b1;
        tick();

        load(4'd0, 8'h0A);
        load(4'd1, 8'h15);
        load(4'd2, 8'hC4);
        for (int i = 3; i < 16; i++) load(4'(i), 8'(8'h30 + i));

        // Three-instruction run, first-issue timing, results and stability
        clear_mon();
        go(5'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_exec_setup", 32'(execute), 32'd0);
        tick();
        chk("t1_instr_fetch", 32'(instruction), 32'h0A);
        chk("t1_exec_still_low", 32'(execute), 32'd0);
        tick();
        chk("t1_exec_rise", 32'(execute), 32'd1);
        wait_fin("t1_finish_wait", 100);
        tick();
        chk("t1_n_exec", 32'(n_exec), 32'd3);
        chk("t1_n_rv", 32'(n_rv), 32'd3);
        chk("t1_n_fin", 32'(n_fin), 32'd1);
        chk("t1_result_leds", 32'(result_leds), 32'hF);
        chk("t1_rv0", 32'(rv_q[0]), 32'h1);
        chk("t1_rv1", 32'(rv_q[1]), 32'hE);
        chk("t1_issued0", 32'(issued_q[0]), 32'h0A);
        chk("t1_issued1", 32'(issued_q[1]), 32'h15);
        chk("t1_issued2", 32'(issued_q[2]), 32'hC4);
        chk("t1_opcode2", 32'(opcode_of(issued_q[2])), 32'(OP_ADD));
        chk("t1_pc_seq", {20'd0, pc_q[0], pc_q[1], pc_q[2]}, 32'h012);
        chk("t1_done_to_exec", 32'(exec_cyc_q[1] - exec_cyc_q[0]), 32'd7);
        chk("t1_stability", 32'(stab_err), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_pc_hold", 32'(pc), 32'd2);
        ticks(3);

        // Done never arrives: timeout exactly TIMEOUT cycles into WAIT_DONE
        model_en = 1'b0;
        clear_mon();
        go(5'd1);
        ticks(3);
        chk("t3_wait_entry", {30'd0, busy, execute}, 32'h2);
        ticks(14);
        chk("t3_no_err_early", 32'(timeout_err), 32'd0);
        chk("t3_busy_early", 32'(busy), 32'd1);
        tick();
        chk("t3_timeout_err", 32'(timeout_err), 32'd1);
        chk("t3_busy_clear", 32'(busy), 32'd0);
        chk("t3_exec_clear", 32'(execute), 32'd0);
        chk("t3_no_result", 32'(n_rv), 32'd0);
        ticks(2);
        chk("t3_err_sticky", 32'(timeout_err), 32'd1);
        model_en = 1'b1;
        go(5'd1);
        chk("t3_err_cleared", 32'(timeout_err), 32'd0);
        wait_fin("t3_rerun_finish", 60);
        ticks(3);

        // Asynchronous reset while slot 1 is being executed
        clear_mon();
        go(5'd3);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (execute === 1'b1 && pc === 4'd1) seen = 1'b1;
        end
        chk("t4_reach_pulse1", 32'(seen), 32'd1);
        chk("t4_leds_before", 32'(result_leds), 32'h1);
        reset = 1'b0;
        #1;
        chk("t4_rst_exec", 32'(execute), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_pc", 32'(pc), 32'd0);
        chk("t4_rst_leds", 32'(result_leds), 32'd0);
        ticks(2);
        reset = 1'b1;
        tick();
        clear_mon();
        go(5'd1);
        ticks(2);
        chk("t4_restart_exec", 32'(execute), 32'd1);
        chk("t4_restart_slot0", 32'(instruction), 32'h0A);
        wait_fin("t4_restart_finish", 60);
        ticks(3);

        // Zero-length and over-length runs
        clear_mon();
        go(5'd0);
        chk("t5_zero_fin", 32'(finished), 32'd1);
        chk("t5_zero_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_zero_fin_pulse", 32'(finished), 32'd0);
        ticks(4);
        chk("t5_zero_no_exec", 32'(n_exec), 32'd0);
        clear_mon();
        go(5'd17);
        wait_fin("t5_sat_finish", 400);
        tick();
        chk("t5_sat_count", 32'(n_exec), 32'd16);
        chk("t5_sat_last", 32'(issued_q[15]), 32'h3F);
        chk("t5_sat_pc", 32'(pc), 32'd15);
        chk("t5_sat_fin", 32'(n_fin), 32'd1);
        ticks(3);

        // Load and start while busy are ignored
        clear_mon();
        go(5'd3);
        tick();
        load_en = 1'b1; load_addr = 4'd2; load_data = 8'hEE;
        prog_len = 5'd1; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        wait_fin("t6_finish", 100);
        ticks(3);
        chk("t6_n_exec", 32'(n_exec), 32'd3);
        chk("t6_slot2", 32'(issued_q[2]), 32'hC4);
        chk("t6_n_fin", 32'(n_fin), 32'd1);

        // Load and start together while idle: the run sees the new word
        clear_mon();
        load_en = 1'b1; load_addr = 4'd0; load_data = 8'h77;
        prog_len = 5'd1; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        wait_fin("t7_finish", 60);
        chk("t7_write_first", 32'(issued_q[0]), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
